// File: rtl/f779_sequencer.sv
// ---------------------------------------------------------------------------
// f779_sequencer
//
// Runs one job on an external 74F779-style 8-bit up/down counter. The job
// parallel-loads a value, counts up or down for a programmed number of
// cycles, turns the shared InotO bus around and reads the result back.
//
// Ports
//   CP        rising-edge clock, shared with the counter
//   RST       synchronous active-high reset
//   start     one-cycle job request, accepted only in IDLE
//   load_val  value parallel-loaded into the counter
//   up        count direction (1 = up, 0 = down)
//   steps     number of count cycles (0..255)
//   S1, S0    counter mode select
//   cet_n     counter count enable, active low
//   oe_n      counter output enable, active low
//   bus_out   data driven onto InotO7..0 during the load
//   bus_oe    1 = this block drives the bus
//   bus_in    sampled state of InotO7..0
//   tc_n      counter terminal count, active low
//   busy      job in progress
//   done      one-cycle pulse at job completion
//   readback  value captured from the bus
//   tc_seen   terminal count observed during the job
//   mismatch  readback differs from the expected value
//
// Configuration
//   F779SEQ_CHECK_EN  when defined, the expected result is computed and
//                     compared in SAMPLE; otherwise mismatch stays 0.
// ---------------------------------------------------------------------------
module f779_sequencer #(
  parameter logic [1:0] MODE_LOAD = 2'b00,
  parameter logic [1:0] MODE_DOWN = 2'b01,
  parameter logic [1:0] MODE_UP   = 2'b10,
  parameter logic [1:0] MODE_HOLD = 2'b11
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] load_val,
  input  logic       up,
  input  logic [7:0] steps,
  output logic       S0,
  output logic       S1,
  output logic       cet_n,
  output logic       oe_n,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  input  logic       tc_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] readback,
  output logic       tc_seen,
  output logic       mismatch
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COUNT  = 3'd2,
    TURN   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] steps_q;
  logic [7:0] cnt;
  logic       up_q;
  logic       accept;
  logic       mismatch_next;

  logic [1:0] mode_next;
  logic       cet_n_next;
  logic       oe_n_next;
  logic       bus_oe_next;
  logic [7:0] bus_out_next;

  assign accept = (state == IDLE) && start;

`ifdef F779SEQ_CHECK_EN
  logic [7:0] load_q;

  // Result the counter should hold after the job, modulo 256.
  function automatic logic [7:0] expected_value(input logic [7:0] base,
                                                input logic       dir_up,
                                                input logic [7:0] n);
    if (dir_up) return base + n;
    else        return base - n;
  endfunction

  // Keeps the job's load value for the end-of-job comparison.
  always_ff @(posedge CP) begin
    if (RST)         load_q <= 8'h00;
    else if (accept) load_q <= load_val;
    else             load_q <= load_q;
  end

  assign mismatch_next = (bus_in != expected_value(load_q, up_q, steps_q));
`else
  assign mismatch_next = 1'b0;
`endif

  // Next-state decode plus the output values belonging to the next state.
  always_comb begin
    next_state   = state;
    mode_next    = MODE_HOLD;
    cet_n_next   = 1'b1;
    oe_n_next    = 1'b1;
    bus_oe_next  = 1'b0;
    bus_out_next = 8'h00;

    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
        else       next_state = IDLE;
      end
      LOAD: begin
        if (steps_q == 8'd0) next_state = TURN;
        else                 next_state = COUNT;
      end
      COUNT: begin
        if (cnt == 8'd1) next_state = TURN;
        else             next_state = COUNT;
      end
      TURN:    next_state = SAMPLE;
      SAMPLE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    case (next_state)
      LOAD: begin
        mode_next    = MODE_LOAD;
        bus_oe_next  = 1'b1;
        bus_out_next = load_val;
      end
      COUNT: begin
        if (up_q) mode_next = MODE_UP;
        else      mode_next = MODE_DOWN;
        cet_n_next = 1'b0;
      end
      TURN: begin
        // Straight from LOAD (steps = 0) the bus driver is only just
        // released, so the counter output stays off one more cycle to keep
        // a dead cycle between the two drivers; SAMPLE still sees the data.
        if (state == LOAD) oe_n_next = 1'b1;
        else               oe_n_next = 1'b0;
      end
      SAMPLE: begin
        oe_n_next = 1'b0;
      end
      DONE: begin
        oe_n_next = 1'b1;
      end
      default: begin
        mode_next = MODE_HOLD;
      end
    endcase
  end

  // State, job parameters, registered outputs and result flags.
  always_ff @(posedge CP) begin
    if (RST) begin
      state    <= IDLE;
      steps_q  <= 8'h00;
      cnt      <= 8'h00;
      up_q     <= 1'b0;
      S1       <= MODE_HOLD[1];
      S0       <= MODE_HOLD[0];
      cet_n    <= 1'b1;
      oe_n     <= 1'b1;
      bus_oe   <= 1'b0;
      bus_out  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      readback <= 8'h00;
      tc_seen  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state   <= next_state;
      S1      <= mode_next[1];
      S0      <= mode_next[0];
      cet_n   <= cet_n_next;
      oe_n    <= oe_n_next;
      bus_oe  <= bus_oe_next;
      bus_out <= bus_out_next;
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);

      if (accept) begin
        steps_q <= steps;
        up_q    <= up;
        cnt     <= steps;
      end else if (state == COUNT) begin
        cnt <= cnt - 8'd1;
      end

      // Result flags restart with each job and are held until the next one.
      if (accept) begin
        tc_seen  <= 1'b0;
        readback <= 8'h00;
        mismatch <= 1'b0;
      end else begin
        if (((state == COUNT) || (state == TURN)) && !tc_n) tc_seen <= 1'b1;
        if (state == SAMPLE) begin
          readback <= bus_in;
          mismatch <= mismatch_next;
        end
      end
    end
  end

endmodule

// File: doc/f779_sequencer.md
F779_SEQUENCER -- requirements
Module: f779_sequencer

Interface
REQ-001 Parameter MODE_LOAD, default 2'b00, the {S1,S0} code that selects parallel load on the counter.
REQ-002 Parameter MODE_DOWN, default 2'b01, the {S1,S0} code that selects count down.
REQ-003 Parameter MODE_UP, default 2'b10, the {S1,S0} code that selects count up.
REQ-004 Parameter MODE_HOLD, default 2'b11, the {S1,S0} code that selects hold.
REQ-005 Ports, clock and reset first: the block SHALL have one clock, CP; reset is synchronous and active-high, RST.
REQ-006 CP  in  1  rising-edge clock, shared with the counter's CP.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle request to run one job.
REQ-009 load_val  in  8  value to parallel-load into the counter.
REQ-010 up  in  1  count direction: 1 = up, 0 = down.
REQ-011 steps  in  8  number of count cycles, 0 to 255.
REQ-012 S0, S1  out  1 each  counter mode select.
REQ-013 \~CET  out  1  counter count enable, active low.
REQ-014 \~OE  out  1  counter output enable, active low.
REQ-015 bus_out  out  8  data driven onto InotO7..0.
REQ-016 bus_oe  out  1  1 = the block drives the bus.
REQ-017 bus_in  in  8  sampled state of InotO7..0.
REQ-018 \~TC  in  1  counter terminal count, active low.
REQ-019 busy  out  1  a job is in progress.
REQ-020 done  out  1  one-cycle pulse when a job completes.
REQ-021 readback  out  8  value captured from the bus.
REQ-022 tc_seen  out  1  sticky per job.
REQ-023 mismatch  out  1  readback differs from the expected value.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, COUNT, TURN, SAMPLE and DONE. All outputs SHALL be registered.
REQ-025 IDLE: when start=1, latch load_val, up and steps, and go to LOAD. While busy=1, start SHALL be ignored.
REQ-026 LOAD lasts exactly 1 cycle, with {S1,S0}=MODE_LOAD, bus_oe=1, bus_out=load_val, \~OE=1 and \~CET=1.
REQ-027 After LOAD the FSM goes to COUNT, or directly to TURN if steps=0.
REQ-028 COUNT lasts exactly steps cycles, with {S1,S0}=MODE_UP or MODE_DOWN per the latched up bit, \~CET=0, bus_oe=0 and \~OE=1. The cycle counter is 8 bits wide.
REQ-029 TURN lasts 1 cycle, with {S1,S0}=MODE_HOLD, \~CET=1, bus_oe=0 and \~OE=0. This is the bus turnaround.
REQ-030 SAMPLE lasts 1 cycle: readback is captured from bus_in at the end of the cycle, and \~OE stays 0.
REQ-031 DONE lasts 1 cycle: done=1, \~OE=1, busy=0 on the following cycle, then return to IDLE.
REQ-032 bus_oe=1 and \~OE=0 SHALL never be asserted in the same cycle.
REQ-033 At least one cycle SHALL separate bus_oe falling from \~OE falling.
REQ-034 tc_seen is cleared on LOAD entry and set if \~TC=0 is sampled during any COUNT or TURN cycle.
REQ-035 Expected value = (load_val + steps) mod 256 when up=1, and (load_val - steps) mod 256 when up=0.
REQ-036 Wrap-around from 255 to 0, and from 0 to 255, SHALL be modulo 256 with no error flag.
REQ-037 busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
REQ-038 readback, tc_seen and mismatch SHALL hold their values until the next LOAD.
REQ-039 Job latency SHALL be start accepted to done = steps + 4 cycles.
REQ-040 start arriving in the same cycle as DONE SHALL be ignored. A new job can be accepted from IDLE only.

Reset
REQ-041 RST=1 at a CP edge SHALL force IDLE with:
- {S1,S0}=MODE_HOLD
- \~CET=1
- \~OE=1
- bus_oe=0
- bus_out=0
- busy=0
- done=0
- readback=0
- tc_seen=0
- mismatch=0
REQ-042 RST asserted in any state, including mid-COUNT, SHALL abort the job with no done pulse.
REQ-043 RST takes priority over start.

Configuration
REQ-044 Macro F779SEQ_CHECK_EN: when defined, the expected value is computed and mismatch is set in SAMPLE if readback differs from it.
REQ-045 When F779SEQ_CHECK_EN is undefined, the expected-value logic is omitted and mismatch is tied to 0.

Verification
REQ-046 Scenario: load_val=8'h10, up=1, steps=5 -> done after 9 cycles, readback=8'h15, tc_seen=0, mismatch=0.
REQ-047 Scenario: load_val=8'hFD, up=1, steps=4 -> readback=8'h01, tc_seen=1 (\~TC low at count 8'hFF), mismatch=0.
REQ-048 Scenario: load_val=8'h02, up=0, steps=3 -> readback=8'hFF, tc_seen=1 (\~TC low at 8'h00).
REQ-049 Scenario: steps=0, load_val=8'hA5 -> COUNT is skipped, done after 4 cycles, readback=8'hA5, and bus_oe and \~OE are never low-active together.
REQ-050 Scenario: RST pulsed during the 3rd COUNT cycle -> next cycle IDLE, \~CET=1, \~OE=1, bus_oe=0, and done is never pulsed.
REQ-051 Scenario: second start while busy, then a counter model forced to return 8'h00 -> the second start is ignored; with F779SEQ_CHECK_EN, mismatch=1; without it, mismatch=0.
